// File: rtl/mux_scan_ctrl_if.sv
// Bus between the mux scan controller and its environment: mux select/return path,
// scan control inputs, and the assembled-word valid/ready output channel.
interface mux_scan_ctrl_if #(
  parameter int NCH   = 4,
  parameter int SEL_W = 2
);
  logic             start;
  logic             mode_cont;
  logic [SEL_W-1:0] sel;
  logic             mux_out;
  logic [NCH-1:0]   word;
  logic             word_valid;
  logic             word_ready;
  logic             busy;
  logic             overrun;

  modport master (
    input  start, mode_cont, mux_out, word_ready,
    output sel, word, word_valid, busy, overrun
  );

  modport slave (
    output start, mode_cont, mux_out, word_ready,
    input  sel, word, word_valid, busy, overrun
  );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scans the four channels of a registered 4:1 mux one per cycle, re-assembles the
// serial mux output into a parallel word and offers it over valid/ready.
module mux_scan_ctrl #(
  parameter int NCH   = 4,
  parameter int SEL_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  mux_scan_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NCH - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             busy_q, busy_d;
  logic [SEL_W-1:0] cap_ch_q, cap_ch_d;
  logic             cap_v_q, cap_v_d;
  logic [NCH-2:0]   shift_q, shift_d;
  logic [NCH-1:0]   word_q, word_d;
  logic             word_valid_q, word_valid_d;
  logic             overrun_q, overrun_d;

  logic             load_s;
  logic             xfer_s;

  // Scan sequencer: select stepping and state transitions.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      IDLE: begin
        sel_d = '0;
        if (bus.start) begin
          state_d = SCAN;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        // mode_cont is only consulted at the end of a full 4-channel pass
        if (sel_q == SEL_LAST) begin
          sel_d = '0;
          if (bus.mode_cont) begin
            state_d = SCAN;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          sel_d   = sel_q + SEL_W'(1);
          state_d = SCAN;
        end
      end
      DRAIN: begin
        sel_d   = '0;
        state_d = IDLE;
      end
      default: begin
        sel_d   = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Capture path: the mux output lags sel by one cycle, so track the bit in flight.
  always_comb begin
    cap_v_d  = (state_q == SCAN);
    cap_ch_d = sel_q;
    shift_d  = shift_q;
    for (int k = 0; k < NCH - 1; k++) begin
      if (cap_v_q && (cap_ch_q == SEL_W'(k))) begin
        shift_d[k] = bus.mux_out;
      end else begin
        shift_d[k] = shift_q[k];
      end
    end
  end

  assign load_s = cap_v_q && (cap_ch_q == SEL_LAST);
  assign xfer_s = word_valid_q && bus.word_ready;

  // Output word register: load, hold under backpressure, or drop and flag overrun.
  always_comb begin
    word_d       = word_q;
    word_valid_d = word_valid_q;
    overrun_d    = overrun_q;
    if (load_s) begin
      if (!word_valid_q || bus.word_ready) begin
        word_d       = {bus.mux_out, shift_q};
        word_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (xfer_s) begin
      word_valid_d = 1'b0;
    end else begin
      word_valid_d = word_valid_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      busy_q       <= 1'b0;
      cap_ch_q     <= '0;
      cap_v_q      <= 1'b0;
      shift_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      cap_ch_q     <= cap_ch_d;
      cap_v_q      <= cap_v_d;
      shift_q      <= shift_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.busy       = busy_q;
  assign bus.word       = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: models the registered 4:1 mux and scoreboards
// every transferred word against the values expected from the channel inputs.
module tb_mux_scan_ctrl;

  logic       clk;
  logic       rst;
  logic [3:0] chan;
  int         errors;
  int         checks;
  logic [3:0] sb[$];
  int         nvalid;

  mux_scan_ctrl_if #(.NCH(4), .SEL_W(2)) bus ();

  mux_scan_ctrl #(.NCH(4), .SEL_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered 4:1 mux: chan[k] is input i(k+1).
  always @(posedge clk) bus.mux_out <= chan[bus.sel];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 60) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(n < 60), 32'd1);
  endtask

  // Scoreboard: every transfer must match the oldest outstanding expected word.
  always @(negedge clk) begin
    if (!rst && bus.word_valid && bus.word_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_word", 32'(bus.word), 32'hFFFF_FFFF);
      end else begin
        chk("sb_word", 32'(bus.word), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    chan = 4'b0000;
    bus.start = 1'b0;
    bus.mode_cont = 1'b0;
    bus.word_ready = 1'b0;
    step(); step(); step();
    rst = 1'b0;

    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_word", 32'(bus.word), 32'd0);
    chk("rst_valid", 32'(bus.word_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);

    // Single scan, i1..i4 = 1,0,1,1
    chan = 4'b1101;
    bus.word_ready = 1'b1;
    sb.push_back(4'b1101);
    pulse_start();
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) step();
      chk("single_sel", 32'(bus.sel), (c <= 4) ? 32'(c - 1) : 32'd0);
      chk("single_valid", 32'(bus.word_valid), 32'(c == 6));
      if (c <= 5 || c >= 7) chk("single_busy", 32'(bus.busy), 32'(c <= 5));
      if (c == 6) chk("single_word", 32'(bus.word), 32'h0000_000D);
    end
    chk("single_overrun", 32'(bus.overrun), 32'd0);

    // Backpressure hold
    bus.word_ready = 1'b0;
    sb.push_back(4'b1101);
    pulse_start();
    repeat (5) step();
    for (int c = 0; c < 10; c++) begin
      chk("hold_valid", 32'(bus.word_valid), 32'd1);
      chk("hold_word", 32'(bus.word), 32'h0000_000D);
      step();
    end
    bus.word_ready = 1'b1;
    step();
    chk("hold_release_valid", 32'(bus.word_valid), 32'd0);
    wait_idle();

    // Continuous mode, mode_cont dropped mid second pass
    chan = 4'b0001;
    bus.mode_cont = 1'b1;
    sb.push_back(4'b0001);
    sb.push_back(4'b1110);
    pulse_start();
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) step();
      if (c == 5) begin
        chan = 4'b1110;
        bus.mode_cont = 1'b0;
      end
      if (c <= 9) chk("cont_sel", 32'(bus.sel), (c <= 8) ? 32'((c - 1) % 4) : 32'd0);
      chk("cont_valid", 32'(bus.word_valid), 32'(c == 6 || c == 10));
      if (c == 6) chk("cont_word0", 32'(bus.word), 32'h0000_0001);
      if (c == 10) chk("cont_word1", 32'(bus.word), 32'h0000_000E);
    end
    wait_idle();
    step();

    // Overrun: first word retained, second dropped
    chan = 4'b1010;
    bus.mode_cont = 1'b1;
    bus.word_ready = 1'b0;
    sb.push_back(4'b1010);
    pulse_start();
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) step();
      if (c == 5) chan = 4'b0101;
      if (c == 9) chk("ovr_before", 32'(bus.overrun), 32'd0);
      if (c == 10) chk("ovr_set", 32'(bus.overrun), 32'd1);
    end
    chk("ovr_word", 32'(bus.word), 32'h0000_000A);
    bus.mode_cont = 1'b0;
    wait_idle();
    step();
    chk("ovr_sticky", 32'(bus.overrun), 32'd1);
    chk("ovr_word_kept", 32'(bus.word), 32'h0000_000A);
    bus.word_ready = 1'b1;
    step();
    step();
    chk("ovr_sticky_after_xfer", 32'(bus.overrun), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ovr_cleared", 32'(bus.overrun), 32'd0);

    // Simultaneous load and transfer
    chan = 4'b0011;
    bus.mode_cont = 1'b1;
    bus.word_ready = 1'b0;
    sb.push_back(4'b0011);
    sb.push_back(4'b1100);
    sb.push_back(4'b1100);
    pulse_start();
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) step();
      if (c == 5) chan = 4'b1100;
      if (c == 9) bus.word_ready = 1'b1;
      if (c == 10) begin
        chk("simul_word", 32'(bus.word), 32'h0000_000C);
        chk("simul_valid", 32'(bus.word_valid), 32'd1);
        chk("simul_overrun", 32'(bus.overrun), 32'd0);
        bus.mode_cont = 1'b0;
      end
    end
    wait_idle();
    step();

    // Start while busy is ignored
    chan = 4'b0110;
    sb.push_back(4'b0110);
    nvalid = 0;
    pulse_start();
    for (int c = 1; c <= 15; c++) begin
      if (c > 1) step();
      if (c <= 5) chk("ign_sel", 32'(bus.sel), (c <= 4) ? 32'(c - 1) : 32'd0);
      if (bus.word_valid) nvalid++;
      bus.start = (c == 2);
    end
    chk("ign_word_count", 32'(nvalid), 32'd1);

    // Reset mid-scan
    chan = 4'b1111;
    pulse_start();
    step();
    step();
    chk("midrst_sel2", 32'(bus.sel), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_sel", 32'(bus.sel), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_valid", 32'(bus.word_valid), 32'd0);
    nvalid = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      if (bus.word_valid) nvalid++;
    end
    chk("midrst_no_word", 32'(nvalid), 32'd0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
